// File: rtl/ct_lsu_pipe3_wakeup_gen_if.sv
// Wakeup-protocol bundle between load pipe 3 (master) and the IDU dependency entries (slave).
// Carries issue, pipe-status, flush and refill inputs plus the AG/DC/DA/WB broadcasts.
interface ct_lsu_pipe3_wakeup_gen_if #(
    parameter int unsigned PREG_W = 7
);
    logic              rtu_yy_xx_flush;
    logic              idu_lsu_rf_pipe3_sel;
    logic              idu_lsu_rf_pipe3_dst_vld;
    logic [PREG_W-1:0] idu_lsu_rf_pipe3_preg;
    logic              lsu_ag_pipe3_stall;
    logic              lsu_dc_pipe3_fwd_ok;
    logic              lsu_da_pipe3_hit;
    logic              lsu_refill_done;

    logic              lsu_idu_ag_pipe3_load_inst_vld;
    logic [PREG_W-1:0] lsu_idu_ag_pipe3_preg_dupx;
    logic              lsu_idu_dc_pipe3_load_inst_vld_dupx;
    logic              lsu_idu_dc_pipe3_load_fwd_inst_vld_dupx;
    logic [PREG_W-1:0] lsu_idu_dc_pipe3_preg_dupx;
    logic              lsu_idu_da_pipe3_cancel_vld;
    logic [PREG_W-1:0] lsu_idu_da_pipe3_preg_dupx;
    logic              lsu_idu_wb_pipe3_wb_preg_vld_dupx;
    logic [PREG_W-1:0] lsu_idu_wb_pipe3_wb_preg_dupx;
    logic              lsu_da_pipe3_replay;

    modport master (
        input  rtu_yy_xx_flush,
        input  idu_lsu_rf_pipe3_sel,
        input  idu_lsu_rf_pipe3_dst_vld,
        input  idu_lsu_rf_pipe3_preg,
        input  lsu_ag_pipe3_stall,
        input  lsu_dc_pipe3_fwd_ok,
        input  lsu_da_pipe3_hit,
        input  lsu_refill_done,
        output lsu_idu_ag_pipe3_load_inst_vld,
        output lsu_idu_ag_pipe3_preg_dupx,
        output lsu_idu_dc_pipe3_load_inst_vld_dupx,
        output lsu_idu_dc_pipe3_load_fwd_inst_vld_dupx,
        output lsu_idu_dc_pipe3_preg_dupx,
        output lsu_idu_da_pipe3_cancel_vld,
        output lsu_idu_da_pipe3_preg_dupx,
        output lsu_idu_wb_pipe3_wb_preg_vld_dupx,
        output lsu_idu_wb_pipe3_wb_preg_dupx,
        output lsu_da_pipe3_replay
    );

    modport slave (
        output rtu_yy_xx_flush,
        output idu_lsu_rf_pipe3_sel,
        output idu_lsu_rf_pipe3_dst_vld,
        output idu_lsu_rf_pipe3_preg,
        output lsu_ag_pipe3_stall,
        output lsu_dc_pipe3_fwd_ok,
        output lsu_da_pipe3_hit,
        output lsu_refill_done,
        input  lsu_idu_ag_pipe3_load_inst_vld,
        input  lsu_idu_ag_pipe3_preg_dupx,
        input  lsu_idu_dc_pipe3_load_inst_vld_dupx,
        input  lsu_idu_dc_pipe3_load_fwd_inst_vld_dupx,
        input  lsu_idu_dc_pipe3_preg_dupx,
        input  lsu_idu_da_pipe3_cancel_vld,
        input  lsu_idu_da_pipe3_preg_dupx,
        input  lsu_idu_wb_pipe3_wb_preg_vld_dupx,
        input  lsu_idu_wb_pipe3_wb_preg_dupx,
        input  lsu_da_pipe3_replay
    );
endinterface

// File: rtl/ct_lsu_pipe3_wakeup_gen.sv
// Load pipe 3 wakeup producer: AG/DC/DA/WB preg broadcasts plus a one-entry refill-wait slot.
// Defining LSU_PIPE3_DC_FWD_EN enables the DC forward broadcast; otherwise it is tied low.
module ct_lsu_pipe3_wakeup_gen #(
    parameter int unsigned PREG_W = 7
) (
    input logic                        forever_cpuclk,
    input logic                        cpurst_b,
    input logic                        cp0_yy_clk_en,
    input logic                        cp0_idu_icg_en,
    input logic                        pad_yy_icg_scan_en,
    ct_lsu_pipe3_wakeup_gen_if.master  bus
);
    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StWait  = 2'd1,
        StReady = 2'd2
    } slot_state_e;

    slot_state_e       r_slot_state, w_slot_state_nxt;
    logic              r_ag_vld, r_dc_vld, r_da_vld, r_wb_vld;
    logic              w_ag_vld_nxt, w_dc_vld_nxt, w_da_vld_nxt, w_wb_vld_nxt;
    logic [PREG_W-1:0] r_ag_preg, r_dc_preg, r_da_preg, r_wb_preg, r_slot_preg;
    logic              w_flush, w_stall, w_da_hit, w_da_miss;
    logic              w_slot_capture, w_slot_wb, w_replay;
    logic              w_local_en, w_vld_clk_en;

    assign w_flush   = bus.rtu_yy_xx_flush;
    assign w_stall   = bus.lsu_ag_pipe3_stall;
    assign w_da_hit  = r_da_vld & bus.lsu_da_pipe3_hit;
    assign w_da_miss = r_da_vld & ~bus.lsu_da_pipe3_hit;

    // Functional equivalent of the gated_clk_cell in front of the valid/state flops.
    assign w_local_en = r_ag_vld | r_dc_vld | r_da_vld | r_wb_vld | bus.idu_lsu_rf_pipe3_sel
                      | (r_slot_state != StIdle) | w_flush;
    assign w_vld_clk_en = pad_yy_icg_scan_en
                        | (cp0_yy_clk_en & (cp0_idu_icg_en | w_local_en));

    always_comb begin
        w_slot_state_nxt = r_slot_state;
        w_slot_capture   = 1'b0;
        w_slot_wb        = 1'b0;
        w_replay         = 1'b0;
        unique case (r_slot_state)
            StIdle: begin
                // A same-cycle refill_done is ignored: the capture takes the slot.
                if (w_da_miss) begin
                    w_slot_state_nxt = StWait;
                    w_slot_capture   = 1'b1;
                end
            end
            StWait: begin
                w_replay = w_da_miss;
                if (bus.lsu_refill_done) begin
                    w_slot_state_nxt = StReady;
                end
            end
            StReady: begin
                w_replay = w_da_miss;
                if (!w_da_hit) begin
                    w_slot_state_nxt = StIdle;
                    w_slot_wb        = 1'b1;
                end
            end
            default: w_slot_state_nxt = StIdle;
        endcase
        if (w_flush) begin
            w_slot_state_nxt = StIdle;
            w_slot_capture   = 1'b0;
            w_slot_wb        = 1'b0;
        end
    end

    always_comb begin
        w_ag_vld_nxt = 1'b0;
        w_dc_vld_nxt = 1'b0;
        w_da_vld_nxt = 1'b0;
        w_wb_vld_nxt = 1'b0;
        if (!w_flush) begin
            w_ag_vld_nxt = w_stall ? r_ag_vld
                                   : (bus.idu_lsu_rf_pipe3_sel & bus.idu_lsu_rf_pipe3_dst_vld);
            w_dc_vld_nxt = r_ag_vld & ~w_stall;
            w_da_vld_nxt = r_dc_vld;
            w_wb_vld_nxt = w_da_hit | w_slot_wb;
        end
    end

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            r_ag_vld     <= 1'b0;
            r_dc_vld     <= 1'b0;
            r_da_vld     <= 1'b0;
            r_wb_vld     <= 1'b0;
            r_slot_state <= StIdle;
        end else if (w_vld_clk_en) begin
            r_ag_vld     <= w_ag_vld_nxt;
            r_dc_vld     <= w_dc_vld_nxt;
            r_da_vld     <= w_da_vld_nxt;
            r_wb_vld     <= w_wb_vld_nxt;
            r_slot_state <= w_slot_state_nxt;
        end
    end

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            r_ag_preg   <= '0;
            r_dc_preg   <= '0;
            r_da_preg   <= '0;
            r_wb_preg   <= '0;
            r_slot_preg <= '0;
        end else begin
            if (!w_stall) begin
                r_ag_preg <= bus.idu_lsu_rf_pipe3_preg;
            end
            if (r_ag_vld && !w_stall) begin
                r_dc_preg <= r_ag_preg;
            end
            if (r_dc_vld) begin
                r_da_preg <= r_dc_preg;
            end
            if (w_da_hit) begin
                r_wb_preg <= r_da_preg;
            end else if (w_slot_wb) begin
                r_wb_preg <= r_slot_preg;
            end
            if (w_slot_capture) begin
                r_slot_preg <= r_da_preg;
            end
        end
    end

    assign bus.lsu_idu_ag_pipe3_load_inst_vld      = r_ag_vld;
    assign bus.lsu_idu_ag_pipe3_preg_dupx          = r_ag_preg;
    assign bus.lsu_idu_dc_pipe3_load_inst_vld_dupx = r_dc_vld;
    assign bus.lsu_idu_dc_pipe3_preg_dupx          = r_dc_preg;
    assign bus.lsu_idu_da_pipe3_cancel_vld         = w_da_miss;
    assign bus.lsu_idu_da_pipe3_preg_dupx          = r_da_preg;
    assign bus.lsu_idu_wb_pipe3_wb_preg_vld_dupx   = r_wb_vld;
    assign bus.lsu_idu_wb_pipe3_wb_preg_dupx       = r_wb_preg;
    assign bus.lsu_da_pipe3_replay                 = w_replay;

`ifdef LSU_PIPE3_DC_FWD_EN
    assign bus.lsu_idu_dc_pipe3_load_fwd_inst_vld_dupx = r_dc_vld & bus.lsu_dc_pipe3_fwd_ok;
`else
    logic w_unused_fwd_ok;
    assign w_unused_fwd_ok = bus.lsu_dc_pipe3_fwd_ok;
    assign bus.lsu_idu_dc_pipe3_load_fwd_inst_vld_dupx = 1'b0;
`endif
endmodule

// File: tb/tb_ct_lsu_pipe3_wakeup_gen.sv
// Scoreboard bench for ct_lsu_pipe3_wakeup_gen: a load-list reference model queues expected
// broadcasts per cycle, and a negedge monitor matches them against the DUT outputs.
module tb_ct_lsu_pipe3_wakeup_gen;
    localparam int unsigned PREG_W = 7;
`ifdef LSU_PIPE3_DC_FWD_EN
    localparam bit FwdEn = 1'b1;
`else
    localparam bit FwdEn = 1'b0;
`endif
    localparam int SAg = 0, SDc = 1, SFwd = 2, SCancel = 3, SReplay = 4, SWb = 5;
    localparam int NStream = 6;

    typedef struct { int cyc; int sid; int preg; } ev_t;
    typedef struct { int preg; int stage; } ld_t;  // stage 1=AG 2=DC 3=DA

    logic clk = 1'b0;
    logic rst_b;
    logic clk_en, icg_en, scan_en;

    int   cyc = 0;
    bit   chk_en = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;
    ev_t  exp_q[$];
    ld_t  pipe_m[$];
    int   slot_phase = 0;  // 0 free, 1 waiting for refill, 2 refill returned
    int   slot_preg_m = 0;
    string nm[NStream] = '{"ag_vld", "dc_vld", "dc_fwd", "da_cancel", "da_replay", "wb_vld"};

    ct_lsu_pipe3_wakeup_gen_if #(.PREG_W(PREG_W)) bus ();

    ct_lsu_pipe3_wakeup_gen #(.PREG_W(PREG_W)) u_dut (
        .forever_cpuclk     (clk),
        .cpurst_b           (rst_b),
        .cp0_yy_clk_en      (clk_en),
        .cp0_idu_icg_en     (icg_en),
        .pad_yy_icg_scan_en (scan_en),
        .bus                (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_b) begin
            assert (!(bus.idu_lsu_rf_pipe3_sel && bus.lsu_ag_pipe3_stall));
        end
    end

    task automatic push_ev(input int c, input int s, input int p);
        ev_t e;
        e.cyc = c; e.sid = s; e.preg = p;
        exp_q.push_back(e);
    endtask

    // Reference model: a list of in-flight loads plus a refill-slot phase.
    task automatic model_step(input bit sel, input bit dst, input int preg, input bit stall,
                              input bit fwd, input bit hit, input bit done, input bit flush);
        ld_t nq[$];
        ld_t l;
        int  da_p;
        int  wb_p;
        int  nphase;
        da_p = -1; wb_p = -1; nphase = slot_phase;
        foreach (pipe_m[i]) begin
            if (pipe_m[i].stage == 1) push_ev(cyc, SAg, pipe_m[i].preg);
            else if (pipe_m[i].stage == 2) begin
                push_ev(cyc, SDc, pipe_m[i].preg);
                if (FwdEn && fwd) push_ev(cyc, SFwd, -1);
            end else da_p = pipe_m[i].preg;
        end
        if (da_p >= 0 && hit) wb_p = da_p;
        else if (slot_phase == 2) begin
            wb_p = slot_preg_m;
            nphase = 0;
        end
        if (da_p >= 0 && !hit) begin
            push_ev(cyc, SCancel, da_p);
            if (slot_phase == 0) begin
                nphase = 1;
                slot_preg_m = da_p;
            end else push_ev(cyc, SReplay, -1);
        end
        if (slot_phase == 1 && done) nphase = 2;
        if (flush) begin
            pipe_m.delete();
            slot_phase = 0;
        end else begin
            if (wb_p >= 0) push_ev(cyc + 1, SWb, wb_p);
            foreach (pipe_m[i]) begin
                l = pipe_m[i];
                if (l.stage == 1 && stall) nq.push_back(l);
                else if (l.stage < 3) begin
                    l.stage = l.stage + 1;
                    nq.push_back(l);
                end
            end
            if (sel && dst) begin
                l.preg = preg; l.stage = 1;
                nq.push_back(l);
            end
            pipe_m = nq;
            slot_phase = nphase;
        end
    endtask

    task automatic step(input bit sel, input bit dst, input int preg, input bit stall,
                        input bit fwd, input bit hit, input bit done, input bit flush);
        @(posedge clk);
        #1;
        cyc++;
        if (stall) sel = 1'b0;
        bus.idu_lsu_rf_pipe3_sel     = sel;
        bus.idu_lsu_rf_pipe3_dst_vld = dst;
        bus.idu_lsu_rf_pipe3_preg    = PREG_W'(preg);
        bus.lsu_ag_pipe3_stall       = stall;
        bus.lsu_dc_pipe3_fwd_ok      = fwd;
        bus.lsu_da_pipe3_hit         = hit;
        bus.lsu_refill_done          = done;
        bus.rtu_yy_xx_flush          = flush;
        model_step(sel, dst, preg & 'h7f, stall, fwd, hit, done, flush);
    endtask

    task automatic idle(input int n, input bit hit);
        repeat (n) step(0, 0, 0, 0, 1, hit, 0, 0);
    endtask

    task automatic zero_inputs();
        bus.idu_lsu_rf_pipe3_sel     = 1'b0;
        bus.idu_lsu_rf_pipe3_dst_vld = 1'b0;
        bus.idu_lsu_rf_pipe3_preg    = '0;
        bus.lsu_ag_pipe3_stall       = 1'b0;
        bus.lsu_dc_pipe3_fwd_ok      = 1'b0;
        bus.lsu_da_pipe3_hit         = 1'b0;
        bus.lsu_refill_done          = 1'b0;
        bus.rtu_yy_xx_flush          = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        logic [33:0] all;
        all = {bus.lsu_idu_ag_pipe3_load_inst_vld, bus.lsu_idu_ag_pipe3_preg_dupx,
               bus.lsu_idu_dc_pipe3_load_inst_vld_dupx, bus.lsu_idu_dc_pipe3_load_fwd_inst_vld_dupx,
               bus.lsu_idu_dc_pipe3_preg_dupx, bus.lsu_idu_da_pipe3_cancel_vld,
               bus.lsu_idu_da_pipe3_preg_dupx, bus.lsu_idu_wb_pipe3_wb_preg_vld_dupx,
               bus.lsu_idu_wb_pipe3_wb_preg_dupx, bus.lsu_da_pipe3_replay};
        n_cmp++;
        if (all !== '0) begin
            n_err++;
            $display("FAIL %s got outputs=%0h want 0", tag, all);
        end
    endtask

    task automatic check_cycle();
        logic act_v[NStream];
        int   act_p[NStream];
        int   idx;
        bit   exp_v;
        int   exp_p;
        act_v[SAg]     = bus.lsu_idu_ag_pipe3_load_inst_vld;
        act_p[SAg]     = int'(bus.lsu_idu_ag_pipe3_preg_dupx);
        act_v[SDc]     = bus.lsu_idu_dc_pipe3_load_inst_vld_dupx;
        act_p[SDc]     = int'(bus.lsu_idu_dc_pipe3_preg_dupx);
        act_v[SFwd]    = bus.lsu_idu_dc_pipe3_load_fwd_inst_vld_dupx;
        act_p[SFwd]    = -1;
        act_v[SCancel] = bus.lsu_idu_da_pipe3_cancel_vld;
        act_p[SCancel] = int'(bus.lsu_idu_da_pipe3_preg_dupx);
        act_v[SReplay] = bus.lsu_da_pipe3_replay;
        act_p[SReplay] = -1;
        act_v[SWb]     = bus.lsu_idu_wb_pipe3_wb_preg_vld_dupx;
        act_p[SWb]     = int'(bus.lsu_idu_wb_pipe3_wb_preg_dupx);
        for (int s = 0; s < NStream; s++) begin
            idx = -1;
            foreach (exp_q[i]) begin
                if (idx < 0 && exp_q[i].cyc == cyc && exp_q[i].sid == s) idx = i;
            end
            exp_v = (idx >= 0);
            exp_p = exp_v ? exp_q[idx].preg : -1;
            if (exp_v) exp_q.delete(idx);
            n_cmp++;
            if (act_v[s] !== exp_v || (exp_v && exp_p >= 0 && act_p[s] != exp_p)) begin
                n_err++;
                $display("FAIL %s cyc=%0d got vld=%0b preg=%0h want vld=%0b preg=%0h",
                         nm[s], cyc, act_v[s], act_p[s], exp_v, exp_p);
            end
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) check_cycle();
    end

    task automatic mid_reset();
        @(posedge clk);
        #3;
        chk_en = 1'b0;
        rst_b  = 1'b0;
        zero_inputs();
        #1;
        chk_zero("async_reset");
        exp_q.delete();
        pipe_m.delete();
        slot_phase = 0;
        repeat (2) @(posedge clk);
        #2;
        rst_b  = 1'b1;
        chk_en = 1'b1;
    endtask

    initial begin
        rst_b   = 1'b0;
        clk_en  = 1'b1;
        icg_en  = 1'b0;
        scan_en = 1'b0;
        zero_inputs();
        #3;
        chk_zero("reset_state");
        repeat (2) @(posedge clk);
        #2;
        rst_b  = 1'b1;
        chk_en = 1'b1;

        // Hit path
        step(1, 1, 'h2A, 0, 1, 1, 0, 0);
        idle(6, 1);
        // AG stall for two cycles
        step(1, 1, 'h05, 0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0, 1, 0, 0);
        idle(6, 1);
        // Miss then refill
        step(1, 1, 'h11, 0, 0, 1, 0, 0);
        idle(2, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        idle(4, 1);
        step(0, 0, 0, 0, 0, 1, 1, 0);
        idle(5, 1);
        // WB collision: slot READY with a DA hit
        step(1, 1, 'h11, 0, 0, 1, 0, 0);
        idle(1, 1);
        step(1, 1, 'h22, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 1, 0);
        step(0, 0, 0, 0, 0, 1, 0, 0);
        idle(5, 1);
        // Slot busy: second miss replays
        step(1, 1, 'h11, 0, 0, 1, 0, 0);
        step(1, 1, 'h33, 0, 0, 1, 0, 0);
        idle(1, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        idle(3, 1);
        step(0, 0, 0, 0, 0, 1, 1, 0);
        idle(5, 1);
        // Flush with AG/DC/DA busy and slot waiting, later refill_done ignored
        step(1, 1, 'h11, 0, 0, 1, 0, 0);
        idle(1, 1);
        step(1, 1, 'h40, 0, 0, 1, 0, 0);
        step(1, 1, 'h41, 0, 0, 0, 0, 0);
        step(1, 1, 'h42, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 1, 0, 1);
        idle(1, 1);
        step(0, 0, 0, 0, 0, 1, 1, 0);
        idle(5, 1);
        // Capture in IDLE beats a same-cycle refill_done
        step(1, 1, 'h50, 0, 0, 1, 0, 0);
        idle(2, 1);
        step(0, 0, 0, 0, 0, 0, 1, 0);
        idle(3, 1);
        step(0, 0, 0, 0, 0, 1, 1, 0);
        idle(5, 1);
        // Reset with loads in flight
        step(1, 1, 'h60, 0, 0, 1, 0, 0);
        step(1, 1, 'h61, 0, 0, 1, 0, 0);
        mid_reset();
        idle(3, 1);

        for (int i = 0; i < 2000; i++) begin
            bit st;
            st = ($urandom_range(0, 99) < 15);
            icg_en = ($urandom_range(0, 99) < 20);
            step(!st && ($urandom_range(0, 99) < 60), ($urandom_range(0, 99) < 85),
                 int'($urandom_range(0, 127)), st, 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 99) < 70), ($urandom_range(0, 99) < 12),
                 ($urandom_range(0, 99) < 2));
            if (i == 1000) mid_reset();
        end

        step(0, 0, 0, 0, 0, 1, 0, 1);
        idle(3, 1);
        @(negedge clk);
        #2;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL leftover_expected got %0d pending want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/ct_lsu_pipe3_wakeup_gen.md
Name: ct_lsu_pipe3_wakeup_gen

Overview:
Producer side of the IDU dependency-entry wakeup protocol for load pipe 3. Tracks each issued load's destination preg through AG, DC, DA and WB. Drives the AG match broadcast, the DC speculative ready and forward broadcasts, the DA speculative-cancel broadcast and the WB write-back broadcast consumed by the IDU source-dependency entries. A single refill-wait slot holds one missed load's preg until its refill returns, then writes it back.

Parameters:
PREG_W, 7, physical register index width

Ports:
forever_cpuclk  in  1  clock
cpurst_b  in  1  async active-low reset
cp0_yy_clk_en  in  1  global gate enable
cp0_idu_icg_en  in  1  module gate enable
pad_yy_icg_scan_en  in  1  scan gate bypass
rtu_yy_xx_flush  in  1  pipeline flush, kills all state
idu_lsu_rf_pipe3_sel  in  1  load issued from RF this cycle
idu_lsu_rf_pipe3_dst_vld  in  1  issued load writes a preg
idu_lsu_rf_pipe3_preg  in  PREG_W  destination preg
lsu_ag_pipe3_stall  in  1  AG holds; DC gets a bubble
lsu_dc_pipe3_fwd_ok  in  1  DC data forwardable next cycle
lsu_da_pipe3_hit  in  1  DA data valid (hit)
lsu_refill_done  in  1  pulse; refill for waiting load complete
lsu_idu_ag_pipe3_load_inst_vld  out  1  AG dst valid
lsu_idu_ag_pipe3_preg_dupx  out  PREG_W  AG preg
lsu_idu_dc_pipe3_load_inst_vld_dupx  out  1  DC speculative ready
lsu_idu_dc_pipe3_load_fwd_inst_vld_dupx  out  1  DC forward valid
lsu_idu_dc_pipe3_preg_dupx  out  PREG_W  DC preg
lsu_idu_da_pipe3_cancel_vld  out  1  DA miss; consumers clear rdy
lsu_idu_da_pipe3_preg_dupx  out  PREG_W  DA preg
lsu_idu_wb_pipe3_wb_preg_vld_dupx  out  1  write-back valid
lsu_idu_wb_pipe3_wb_preg_dupx  out  PREG_W  write-back preg
lsu_da_pipe3_replay  out  1  DA miss with refill slot busy; LSU must replay

Behaviour:
- Clock and reset are fixed: a single clock `forever_cpuclk`; `cpurst_b` is asynchronous, active-low. All registers reset via `cpurst_b`.
- Reset values: all stage valids 0, all pregs 0, refill state IDLE. Every output resets to 0.
- Stage registers (ag/dc/da/wb) each hold a valid bit and a preg.
- Valid regs are clocked through `gated_clk_cell` with local_en = any valid || rf_sel || refill state != IDLE || flush.
- Preg regs load only when their stage captures.
- AG stage:
  - If ag_stall, AG holds.
  - Otherwise AG captures: ag_vld <= rf_sel && dst_vld; ag_preg <= rf_preg.
  - rf_sel while ag_stall is illegal; the bench asserts it never occurs.
- DC stage: dc_vld <= ag_vld && !ag_stall.
- DA stage: da_vld <= dc_vld.
- AG/DC/DA outputs are combinational from the stage registers:
  - ag_load_inst_vld = ag_vld.
  - dc_load_inst_vld = dc_vld.
  - dc_fwd = dc_vld && fwd_ok (see Optional Feature).
  - cancel_vld = da_vld && !hit.
- WB register selects its source in priority order:
  1. DA hit: wb_vld <= 1, wb_preg <= da_preg.
  2. Refill slot READY: slot writes back, slot -> IDLE.
  3. Otherwise wb_vld <= 0.
- WB outputs come directly from the WB register. WB latency is exactly 1 cycle after a DA hit.
- Refill slot FSM:
  - IDLE -> WAIT on DA miss; captures da_preg.
  - WAIT -> READY on refill_done.
  - READY -> IDLE when selected for WB.
  - DA miss while slot != IDLE: replay = 1 that cycle, cancel still asserted, slot unchanged.
  - refill_done in IDLE or READY is ignored.
  - A DA miss captured in IDLE and refill_done in the same cycle: the capture wins; the done is ignored.
- Flush (highest priority, synchronous): next cycle all valids = 0 and slot = IDLE.
  - Outputs driven combinationally in the flush cycle still show pre-flush values.
  - A registered WB due next cycle is dropped.
- Mid-operation reset: all state clears asynchronously; outputs go to 0 immediately.

Optional Feature:
LSU_PIPE3_DC_FWD_EN:
- Defined: lsu_idu_dc_pipe3_load_fwd_inst_vld_dupx = dc_vld && lsu_dc_pipe3_fwd_ok.
- Undefined: the output is tied 0, lsu_dc_pipe3_fwd_ok is unused, and consumers rely on rdy/wb only.

Test Plan:
- Hit path. Stimulus: rf_sel=1, dst_vld=1, preg=0x2A at cycle 0, hit=1. Response: ag_vld with 0x2A at c1, dc_vld at c2, wb_vld with 0x2A at c4, cancel never asserted.
- AG stall. Stimulus: issue preg=0x05, ag_stall=1 for cycles 1-2. Response: ag_vld=1 holds c1-c3, dc_vld=1 only at c4, single WB at c6.
- Miss and refill. Stimulus: issue 0x11, hit=0 at DA (c3); refill_done at c8. Response: cancel_vld with 0x11 at c3, slot WAIT, READY at c9, wb with 0x11 at c10.
- WB collision. Stimulus: slot READY (0x11) in the same cycle as a DA hit of 0x22. Response: wb=0x22 first, wb=0x11 the following cycle.
- Slot busy. Stimulus: slot in WAIT (0x11), second load 0x33 misses at DA. Response: cancel_vld and replay=1 that cycle; slot still holds 0x11; no WB of 0x33.
- Flush. Stimulus: flush with loads in AG, DC and DA and slot in WAIT. Response: all valids 0 next cycle, slot IDLE, no WB appears; a later refill_done is ignored.
